alu_serial_ctrl: RTL and testbench

- Bit-serial multi-bit ALU sequencer: accepts WIDTH-bit operands plus a 2-bit mode on a start handshake.
- Evaluates one bit per clock, LSB first, with a registered carry. Uses the same mode encoding as the 1-bit ALU slice: 00 add, 01 AND, 10 OR, 11 XOR.
- Presents the WIDTH-bit result with a one-cycle done pulse.
- Acts as the driving or initiating end for the 1-bit slice datapath. It lets a single slice replace a ripple array when area matters more than latency.

---
 rtl/alu_serial_ctrl.sv | 113 +++++++++++
 tb/tb_alu_serial_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: one result bit per clock, LSB first, registered carry.
// Latency: start accepted at edge k -> busy cycles k+1..k+WIDTH, done pulse after edge k+WIDTH.
// Backpressure: none; start is only sampled in IDLE, ignored (not queued) while busy or done.
module alu_serial_ctrl #(
  parameter int WIDTH = 4,
  parameter int CW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       M,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] f,
  output logic             cout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic [1:0]       md;
  logic             c;
  logic [CW-1:0]    cnt;

  logic             r;
  logic             c_nxt;
  logic [WIDTH-1:0] res_nxt;

  // One-bit slice: result bit and next carry from the operand LSBs and the carry reg.
  always_comb begin
    r     = 1'b0;
    c_nxt = c;
    case (md)
      2'b00: begin
        r     = sa[0] ^ sb[0] ^ c;
        c_nxt = (sa[0] & sb[0]) | (c & (sa[0] ^ sb[0]));
      end
      2'b01:   r = sa[0] & sb[0];
      2'b10:   r = sa[0] | sb[0];
      default: r = sa[0] ^ sb[0];
    endcase
  end

  // New bit enters from the MSB side so after WIDTH shifts bit 0 sits at the LSB.
  assign res_nxt = {r, res[WIDTH-1:1]};

  // Sequencer FSM with registered busy/done/f/cout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      f     <= '0;
      cout  <= 1'b0;
      cnt   <= '0;
      c     <= 1'b0;
      sa    <= '0;
      sb    <= '0;
      res   <= '0;
      md    <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            md    <= M;
            c     <= cin;
            cnt   <= '0;
            res   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          c   <= c_nxt;
          res <= res_nxt;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            f     <= res_nxt;
            cout  <= (md == 2'b00) ? c_nxt : 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
module tb_alu_serial_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [1:0]   m_in;
  logic         busy;
  logic         done;
  logic [W-1:0] f;
  logic         cout;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] prev_f;
  logic         prev_cout;

  alu_serial_ctrl #(.WIDTH(W), .CW(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .M     (m_in),
    .busy  (busy),
    .done  (done),
    .f     (f),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vc;
    logic [1:0]   vm;
    logic [W-1:0] ef;
    logic         ecout;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: whole-word arithmetic, {cout, f}.
  function automatic logic [W:0] ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                           input logic rc, input logic [1:0] rm);
    case (rm)
      2'b00:   return {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      2'b01:   return {1'b0, ra & rb};
      2'b10:   return {1'b0, ra | rb};
      default: return {1'b0, ra ^ rb};
    endcase
  endfunction

  // Issue one operation from IDLE and check latency, hold, result and pulse width.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input logic tc, input logic [1:0] tm, input logic [W:0] e);
    int lat;
    int bc;
    logic hold_ok;
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; m_in = tm; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); m_in = 2'($urandom);
    lat = 0; bc = 0; hold_ok = 1'b1;
    while (!done && lat < 3 * W) begin
      if (busy) bc++;
      if (busy && (f !== prev_f || cout !== prev_cout)) hold_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, W);
    check("busy_cycles", bc, W);
    check("hold_during_run", {31'd0, hold_ok}, 1);
    check("busy_at_done", {31'd0, busy}, 0);
    check("f", {28'd0, f}, {28'd0, e[W-1:0]});
    check("cout", {31'd0, cout}, {31'd0, e[W]});
    prev_f = e[W-1:0];
    prev_cout = e[W];
    @(posedge clk); #1;
    check("done_one_cycle", {31'd0, done}, 0);
  endtask

  initial begin
    int dcnt;
    int bcnt;
    int last;
    logic [W:0] e;
    logic [W-1:0] ra, rb;
    logic rc;
    logic [1:0] rm;

    vecs[0] = '{4'b0101, 4'b0011, 1'b0, 2'b00, 4'b1000, 1'b0};
    vecs[1] = '{4'b1111, 4'b0001, 1'b0, 2'b00, 4'b0000, 1'b1};
    vecs[2] = '{4'b0111, 4'b1000, 1'b1, 2'b00, 4'b0000, 1'b1};
    vecs[3] = '{4'b1100, 4'b1010, 1'b0, 2'b01, 4'b1000, 1'b0};
    vecs[4] = '{4'b1100, 4'b1010, 1'b0, 2'b10, 4'b1110, 1'b0};
    vecs[5] = '{4'b1100, 4'b1010, 1'b0, 2'b11, 4'b0110, 1'b0};
    vecs[6] = '{4'b1100, 4'b1010, 1'b1, 2'b11, 4'b0110, 1'b0};
    vecs[7] = '{4'b1111, 4'b1111, 1'b1, 2'b00, 4'b1111, 1'b1};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; m_in = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_f", {28'd0, f}, 0);
    check("rst_cout", {31'd0, cout}, 0);
    rst = 1'b0;
    prev_f = '0; prev_cout = 1'b0;

    // Directed table, back to back.
    for (int i = 0; i < 8; i++)
      do_op(vecs[i].va, vecs[i].vb, vecs[i].vc, vecs[i].vm, {vecs[i].ecout, vecs[i].ef});

    // Start re-pulsed with other operands while busy and during done.
    @(negedge clk);
    a = 4'b0110; b = 4'b0011; cin = 1'b0; m_in = 2'b00; start = 1'b1;
    @(posedge clk); #1;
    a = 4'b1111; b = 4'b1111; cin = 1'b1; m_in = 2'b10;
    dcnt = 0; bcnt = 0;
    if (busy) bcnt++;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (i == 5) start = 1'b0;
      if (busy) bcnt++;
      if (done) dcnt++;
    end
    check("repulse_done_count", dcnt, 1);
    check("repulse_busy_count", bcnt, W);
    check("repulse_f", {28'd0, f}, 32'b1001);
    check("repulse_cout", {31'd0, cout}, 0);
    prev_f = 4'b1001; prev_cout = 1'b0;

    // Reset two cycles into a run aborts with no done pulse.
    @(negedge clk);
    a = 4'b1111; b = 4'b1111; cin = 1'b1; m_in = 2'b00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_done", {31'd0, done}, 0);
    check("abort_f", {28'd0, f}, 0);
    check("abort_cout", {31'd0, cout}, 0);
    prev_f = '0; prev_cout = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done || busy) dcnt++;
    end
    check("abort_no_activity", dcnt, 0);
    do_op(4'b0010, 4'b0010, 1'b0, 2'b00, {1'b0, 4'b0100});

    // Start held high: done every WIDTH+2 cycles.
    @(negedge clk);
    a = 4'b0001; b = 4'b0001; cin = 1'b0; m_in = 2'b00; start = 1'b1;
    dcnt = 0; last = -1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      if (busy && done) check("busy_done_overlap", 1, 0);
      if (done) begin
        dcnt++;
        check("held_f", {28'd0, f}, 32'b0010);
        if (last >= 0) check("held_spacing", cyc - last, W + 2);
        last = cyc;
      end
    end
    check("held_done_count", dcnt, 6);
    start = 1'b0;
    repeat (2 * W) @(posedge clk);
    #1;
    prev_f = f; prev_cout = cout;
    check("drained_busy", {31'd0, busy}, 0);
    check("drained_f", {28'd0, f}, 32'b0010);

    // Random operations against the word-level model.
    for (int n = 0; n < 150; n++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom); rm = 2'($urandom);
      e = ref_model(ra, rb, rc, rm);
      do_op(ra, rb, rc, rm, e);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
